// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit.
// Covers access sizes, FSM states and lane masks used by the unit and its lane aligner.
package mips_lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: lane_mask = BYTE_MASK;
            SIZE_HALF: lane_mask = HALF_MASK;
            default:   lane_mask = WORD_MASK;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge.
// Assumes the caller has already rejected misaligned accesses.
module lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign shift = {lane, 3'b000};

    always_comb begin
        shifted   = load_word >> shift;
        mask      = lane_mask(size);
        load_data = load_word;
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default:   load_data = load_word;
        endcase
        // Word accesses are aligned, so shift is zero and the whole word is replaced.
        merged_word = (old_word & ~(mask << shift)) | ((new_data & mask) << shift);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MIPS MEM stage and a word-wide data memory.
// Single outstanding request; sub-word stores use read-modify-write.
module load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int MEM_AW      = 9,
    parameter bit CHECK_RANGE = 1'b1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic [MEM_AW-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we
);

    lsu_state_t state, next_state;

    logic              store_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [MEM_AW+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       buf_q;

    logic        accept;
    logic        req_err;
    logic        we_raw;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign accept     = req_valid && req_ready;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_raddr  = addr_q[MEM_AW+1:2];
    assign mem_waddr  = addr_q[MEM_AW+1:2];
    assign mem_we     = we_raw & ~rst;

    always_comb begin
        req_err = 1'b0;
        if (req_size == SIZE_RSVD)                            req_err = 1'b1;
        if (req_size == SIZE_HALF && req_addr[0])             req_err = 1'b1;
        if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)  req_err = 1'b1;
        if (CHECK_RANGE && ((req_addr >> (MEM_AW + 2)) != 32'd0)) req_err = 1'b1;
    end

    lsu_lane_align u_align (
        .load_word   (mem_rdata),
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_signed   (signed_q),
        .old_word    (buf_q),
        .new_data    (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Errored requests still pass through ACCESS (with no write) so every
    // single-access response arrives with the same two-cycle latency.
    always_comb begin
        next_state = state;
        we_raw     = 1'b0;
        mem_wdata  = wdata_q;
        case (state)
            IDLE: begin
                if (accept) next_state = ACCESS;
            end
            ACCESS: begin
                if (err_q || !store_q) begin
                    next_state = RESP;
                end else if (size_q == SIZE_WORD) begin
                    we_raw     = 1'b1;
                    next_state = RESP;
                end else begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                we_raw     = 1'b1;
                mem_wdata  = merged_word;
                next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            size_q     <= SIZE_BYTE;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            buf_q      <= 32'd0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                store_q  <= req_store;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr[MEM_AW+1:0];
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if (state == ACCESS && next_state == WRITE) begin
                buf_q <= mem_rdata;
            end
            // Response fields change only on entry to RESP and hold until the next one.
            if (next_state == RESP && state != RESP) begin
                resp_err   <= err_q;
                resp_rdata <= (state == ACCESS && !store_q && !err_q) ? load_data : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 512x32 async-read memory model.
// Expected responses go into a scoreboard queue at accept and are checked on resp_valid.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [8:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_we;

    logic [31:0] mem [0:511];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;
    int resp_count  = 0;
    int we_count    = 0;

    load_store_unit #(.MEM_AW(9), .CHECK_RANGE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_raddr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
            we_count       <= we_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Response monitor: latency counted from accept edge to the edge that samples resp_valid.
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                checkOutput("resp_rdata", resp_rdata, e.rdata);
                checkOutput("resp_latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic drainQueue();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checkOutput("resp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input logic store, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        exp_t e;
        @(negedge clk);
        req_store  = store;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.err   = exp_err;
        e.rdata = exp_rdata;
        e.lat   = exp_lat;
        e.acc   = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drainQueue();
    endtask

    initial begin
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];
        int          rc;
        int          wc;
        int          low;
        exp_t        e;

        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        rst = 1'b0;

        $display("[TB] word store/load");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 2);
        checkOutput("sw_mem4", mem[4], 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 2);

        $display("[TB] byte store/load");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 1'b0, 32'd0, 3);
        checkOutput("sb_mem4", mem[4], 32'hDEAD55EF);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1'b0, 32'hFFFFFFDE, 2);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0, 32'h000000DE, 2);

        $display("[TB] half store/load");
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, 1'b0, 32'd0, 3);
        checkOutput("sh_mem8", mem[8], 32'h80010000);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 1'b0, 32'hFFFF8001, 2);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 1'b0, 32'h00008001, 2);

        $display("[TB] error cases");
        wc = we_count;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'd0, 1'b1, 32'd0, 2);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h13, 32'd0, 1'b1, 32'd0, 2);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b1, 32'd0, 2);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h800, 32'h12345678, 1'b1, 32'd0, 2);
        checkOutput("err_no_write", we_count, wc);
        checkOutput("err_mem0", mem[0], 32'd0);

        $display("[TB] reset during sub-word write");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 1'b0, 32'd0, 2);
        @(negedge clk);
        req_store  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h41;
        req_wdata  = 32'h000000AA;
        req_valid  = 1'b1;
        checkOutput("rstw_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rc = resp_count;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstw_we_in_write", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstw_ready_after", {31'd0, req_ready}, 32'd1);
        checkOutput("rstw_mem16", mem[16], 32'h11223344);
        repeat (4) @(negedge clk);
        checkOutput("rstw_no_resp", resp_count, rc);

        $display("[TB] back-to-back loads");
        b2b_addr[0] = 32'h10; b2b_data[0] = 32'hDEAD55EF;
        b2b_addr[1] = 32'h20; b2b_data[1] = 32'h80010000;
        b2b_addr[2] = 32'h40; b2b_data[2] = 32'h11223344;
        b2b_addr[3] = 32'h10; b2b_data[3] = 32'hDEAD55EF;
        rc         = resp_count;
        req_store  = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = b2b_addr[0];
        req_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            low = 0;
            for (int i = 0; i < 20 && !req_ready; i++) begin
                low++;
                @(negedge clk);
            end
            if (k > 0) checkOutput("b2b_ready_low", low, 2);
            if (!req_ready) begin
                checkOutput("b2b_accept_timeout", 32'd0, 32'd1);
                break;
            end
            e.err   = 1'b0;
            e.rdata = b2b_data[k];
            e.lat   = 2;
            e.acc   = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (k < 3) req_addr = b2b_addr[k+1];
            else       req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        drainQueue();
        checkOutput("b2b_resp_count", resp_count - rc, 32'd4);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got 0x%08h, expected 0x%08h", cyc, 0);
        $fatal(1, "[TB] timeout");
    end

endmodule
